// File: rtl/servo_ramp_if.sv
// ---------------------------------------------------------------------------
// servo_ramp_if
//   Bundles the CPU register bus and the position output of servo_ramp.
//
//   din      CPU write data
//   address  CPU register address
//   w_en     CPU write strobe
//   r_en     CPU read strobe
//   dout     registered read data
//   pos      current commanded position (feeds the servo register din)
//   pos_wr   one-cycle strobe when pos holds a newly issued value
//   busy     high while a ramp is in progress
//
//   master: CPU / SoC side.  slave: the servo_ramp block.
// ---------------------------------------------------------------------------
interface servo_ramp_if;
    logic [7:0] din;
    logic [7:0] address;
    logic       w_en;
    logic       r_en;
    logic [7:0] dout;
    logic [7:0] pos;
    logic       pos_wr;
    logic       busy;

    modport master (
        output din, address, w_en, r_en,
        input  dout, pos, pos_wr, busy
    );

    modport slave (
        input  din, address, w_en, r_en,
        output dout, pos, pos_wr, busy
    );
endinterface

// File: rtl/servo_ramp.sv
// ---------------------------------------------------------------------------
// servo_ramp
//   Memory-mapped slew-rate limiter placed in front of the servo pulse
//   generator. The CPU programs a target angle and a step period in ms; the
//   block walks pos one LSB at a time toward the target and strobes pos_wr
//   for every new value, so the servo never sees an abrupt jump.
//
//   Registers (relative to BASE_ADDRESS):
//     +0 TARGET   R/W  destination position
//     +1 RATE     R/W  ms per step, 0 = jump immediately
//     +2 POSITION R    current pos
//     +3 STATUS   R    {6'b0, done, busy}; read clears done
//                 W    din[7]=1 aborts the ramp (TARGET <= pos)
//
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset
//     bus  servo_ramp_if.slave: din/address/w_en/r_en/dout/pos/pos_wr/busy
// ---------------------------------------------------------------------------
module servo_ramp #(
    parameter logic [7:0] BASE_ADDRESS = 8'h00,
    parameter int         CLK_FREQ     = 16000000,
    parameter logic [7:0] RESET_POS    = 8'd128
) (
    input  logic         clk,
    input  logic         rst,
    servo_ramp_if.slave  bus
);

    localparam int TICK_DIV = CLK_FREQ / 1000;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_STEP = 2'd3;

    logic [1:0]       state_reg,  state_next;
    logic [7:0]       target_reg, target_next;
    logic [7:0]       rate_reg,   rate_next;
    logic [7:0]       pos_reg,    pos_next;
    logic [7:0]       dout_reg,   dout_next;
    logic             pos_wr_reg, pos_wr_next;
    logic             done_reg,   done_next;
    logic [PRE_W-1:0] pre_reg,    pre_next;
    logic [7:0]       tcnt_reg,   tcnt_next;

    logic             busy;
    logic             tick;
    logic [8:0]       tcnt_inc;
    logic [7:0]       target_eff;
    logic [7:0]       pos_step;

    // ------------------------------------------------------------------
    // Address decode and read mux
    // ------------------------------------------------------------------
    logic [3:0] reg_sel;
    logic [7:0] rd_val  [4];
    logic [7:0] rd_term [4];

    assign rd_val[0] = target_reg;
    assign rd_val[1] = rate_reg;
    assign rd_val[2] = pos_reg;
    assign rd_val[3] = {6'b0, done_reg, busy};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_reg
            assign reg_sel[gi] = (bus.address == BASE_ADDRESS + 8'(gi));
            assign rd_term[gi] = (bus.r_en && reg_sel[gi]) ? rd_val[gi] : 8'd0;
        end
    endgenerate

    // A miss or no read returns 0, so OR-ing the gated terms is the mux.
    assign dout_next = rd_term[0] | rd_term[1] | rd_term[2] | rd_term[3];

    logic wr_target, wr_rate, wr_abort, rd_status;
    assign wr_target = bus.w_en && reg_sel[0];
    assign wr_rate   = bus.w_en && reg_sel[1];
    assign wr_abort  = bus.w_en && reg_sel[3] && bus.din[7];
    assign rd_status = bus.r_en && reg_sel[3];

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    assign busy     = (state_reg == ST_WAIT) || (state_reg == ST_STEP);
    assign tick     = (pre_reg == PRE_LAST);
    assign tcnt_inc = {1'b0, tcnt_reg} + 9'd1;

    // The target as it will stand after this edge; IDLE and WAIT react to a
    // write in the same cycle, STEP deliberately uses the registered value.
    assign target_eff = wr_target ? bus.din : target_reg;

    // Only ever moves toward the target, so 0 and 255 cannot wrap.
    assign pos_step = (target_reg > pos_reg) ? pos_reg + 8'd1 : pos_reg - 8'd1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        rate_next   = rate_reg;
        pos_next    = pos_reg;
        pos_wr_next = 1'b0;
        done_next   = done_reg;
        tcnt_next   = tcnt_reg;
        pre_next    = tick ? '0 : pre_reg + PRE_W'(1);

        // Read-clear first so any set below takes priority.
        if (rd_status) begin
            done_next = 1'b0;
        end
        if (wr_rate) begin
            rate_next = bus.din;
        end
        if (wr_target) begin
            target_next = bus.din;
        end

        if (wr_abort) begin
            target_next = pos_reg;
            state_next  = ST_IDLE;
            done_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    // Hand the servo register its first value.
                    pos_wr_next = 1'b1;
                    state_next  = ST_IDLE;
                end
                ST_IDLE: begin
                    if (target_eff != pos_reg) begin
                        if (rate_reg == 8'd0) begin
                            pos_next    = target_eff;
                            pos_wr_next = 1'b1;
                            done_next   = 1'b1;
                        end else begin
                            state_next = ST_WAIT;
                            pre_next   = '0;
                            tcnt_next  = 8'd0;
                        end
                    end else if (wr_target) begin
                        done_next = 1'b1;
                    end
                end
                ST_WAIT: begin
                    // Also catches a target that landed on pos during STEP.
                    if (target_eff == pos_reg) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else if (tick) begin
                        tcnt_next = tcnt_inc[7:0];
                        // >= so a RATE lowered below the count steps on this tick.
                        if (tcnt_inc >= {1'b0, rate_reg}) begin
                            state_next = ST_STEP;
                        end
                    end
                end
                default: begin // ST_STEP
                    tcnt_next = 8'd0;
                    if (pos_reg != target_reg) begin
                        pos_next    = pos_step;
                        pos_wr_next = 1'b1;
                        if (pos_step == target_reg) begin
                            state_next = ST_IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = ST_WAIT;
                        end
                    end else begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_INIT;
            target_reg <= RESET_POS;
            rate_reg   <= 8'd0;
            pos_reg    <= RESET_POS;
            dout_reg   <= 8'd0;
            pos_wr_reg <= 1'b0;
            done_reg   <= 1'b0;
            pre_reg    <= '0;
            tcnt_reg   <= 8'd0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
            rate_reg   <= rate_next;
            pos_reg    <= pos_next;
            dout_reg   <= dout_next;
            pos_wr_reg <= pos_wr_next;
            done_reg   <= done_next;
            pre_reg    <= pre_next;
            tcnt_reg   <= tcnt_next;
        end
    end

    assign bus.dout   = dout_reg;
    assign bus.pos    = pos_reg;
    assign bus.pos_wr = pos_wr_reg;
    assign bus.busy   = busy;

endmodule

// File: doc/servo_ramp.md
# servo_ramp

Memory-mapped slew-rate limiter that sits directly upstream of the servo pulse generator. The CPU writes a target angle (0–255) and a step rate. The block walks its position output one LSB at a time toward the target, one step every RATE milliseconds. Each new position is issued on `pos`/`pos_wr`, which the SoC wires to the servo register's `din`/`w_en`, so the servo never jumps abruptly.

## Interface
- `BASE_ADDRESS`, 8'h00: register block base; occupies BASE+0..BASE+3.
- `CLK_FREQ`, 16000000: clk frequency in Hz; ms prescaler divide `TICK_DIV = CLK_FREQ/1000`.
- `RESET_POS`, 8'd128: position and target after reset (servo centre).

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  8  CPU write data.
- `address`  in  8  CPU register address.
- `w_en`  in  1  CPU write strobe.
- `r_en`  in  1  CPU read strobe.
- `dout`  out  8  registered read data.
- `pos`  out  8  current commanded position.
- `pos_wr`  out  1  one-cycle strobe, high when `pos` holds a newly issued value.
- `busy`  out  1  high while a ramp is in progress.

## Operation
- **Registers**
  - BASE+0 TARGET (R/W): destination position.
  - BASE+1 RATE (R/W): ms per step; 0 = jump immediately.
  - BASE+2 POSITION (R): `pos`.
  - BASE+3 STATUS: read returns {6'b0, done, busy}. Write with din[7]=1 aborts; other bits ignored.
- **Reset values:** TARGET=`pos`=RESET_POS, RATE=0, `dout`=0, `pos_wr`=0, `busy`=0, done=0, prescaler=0, tick count=0, FSM=INIT.
- **Read path:** when r_en is high and the address hits, `dout` takes the register value at the next edge; otherwise `dout` becomes 0. A STATUS read clears done in the same edge; the value returned is the pre-clear value.
- **Prescaler:** counts 0..TICK_DIV-1 and pulses tick for one cycle on wrap. It and the tick count are cleared on entry to WAIT from IDLE.
- **FSM states:**
  - INIT: `pos_wr`=1 for one cycle with `pos`=RESET_POS, so the servo register gets an initial value; then IDLE.
  - IDLE (`busy`=0): when `pos` != TARGET:
    - RATE=0: `pos`<=TARGET, `pos_wr` pulse, done<=1, stay IDLE.
    - RATE!=0: go to WAIT, `busy`=1.
  - WAIT: count ticks. When tick count reaches RATE, go to STEP. A RATE write takes effect immediately; if the count is already >= the new RATE, step on the next tick.
  - STEP (one cycle): `pos`+1 if TARGET>`pos`, else `pos`-1; `pos_wr` pulse; tick count<=0.
    - New `pos`==TARGET: IDLE, done<=1.
    - Otherwise: WAIT, with the prescaler not cleared.
- **Retarget:** a TARGET write during WAIT is honoured at the next STEP; the direction is re-evaluated there.
  - If the new TARGET equals `pos` at write time: IDLE, done<=1, no `pos_wr`.
  - TARGET written equal to `pos` while IDLE: done<=1.
- **Abort:** in any state, TARGET<=`pos`, FSM<=IDLE, done<=0, no `pos_wr`.
- **Simultaneous events:**
  - TARGET write coinciding with STEP: the step uses the pre-write TARGET; the new TARGET is compared on the following cycle.
  - Abort coinciding with a TARGET write: abort wins.
  - done set and a STATUS read in the same cycle: set wins.
- **Arithmetic:** `pos` never wraps; steps are only taken toward TARGET, so 0 and 255 are reachable and never exceeded.

## Timing
- Register write is visible on `busy`/FSM at the next edge; read data appears one cycle after r_en.
- RATE=0 jump: `pos`/`pos_wr` update one cycle after the TARGET write cycle.
- Ramp step period: exactly RATE×TICK_DIV cycles per step; first step RATE×TICK_DIV+1 cycles after leaving IDLE.
- `busy` falls on the same edge that `pos` reaches TARGET.
- Async reset mid-ramp: all outputs go to reset values immediately, with no `pos_wr`. INIT pulses `pos_wr` on the first edge after `rst` deasserts.

## Test plan
All tests use CLK_FREQ=10000 (TICK_DIV=10).
1. Reset release -> `pos_wr` high exactly one cycle with `pos`=128; STATUS reads 0x00; POSITION reads 0x80.
2. RATE=0, write TARGET=200 -> one `pos_wr` next cycle, `pos`=200; STATUS reads 0x02, then 0x00 on re-read.
3. RATE=2, TARGET=131 from 128 -> `pos_wr` pulses with `pos`=129, 130, 131, spaced 20 cycles; `busy` drops with the 131 step; done=1.
4. RATE=1, TARGET=140; when `pos`=132 write TARGET=130 -> next steps 131, 130, then IDLE, done=1, no further `pos_wr`.
5. RATE=1, TARGET=255 from 250 -> stops at 255 without wrap; then write TARGET=0 -> `pos` decrements toward 0, reaching 0 with no wrap to 255; mid-ramp STATUS write 0x80 -> no more `pos_wr`, TARGET reads `pos`, STATUS reads 0x00.
6. Assert `rst` mid-ramp (`pos`=135) -> `pos`=128, `busy`=0, `dout`=0 without a clock edge; INIT `pos_wr` pulse after release.
